// File: rtl/fir_out_collector_if.sv
// Output stream of the FIR collector: signed scaled samples with valid/ready.
// No logic of its own; carries one sample per accepted transfer.
// The master holds m_data/m_valid stable while m_ready is low.
interface fir_out_collector_if #(
    parameter int OUT_W = 16
);
    logic signed [OUT_W-1:0] m_data;
    logic                    m_valid;
    logic                    m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fir_out_collector.sv
// Collects FIR output, drops warm-up samples, rounds/shifts/saturates, buffers in a FWFT FIFO.
// Latency: sample captured at edge k, written at edge k+1, visible on m_valid after k+1.
// Backpressure: FIFO absorbs stalls; when full, new samples are dropped and overflow sticks.
module fir_out_collector #(
    parameter int N_TAPS = 21,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 7,
    parameter int DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_p,
    input  logic                        sample_en,
    input  logic signed [ACC_W-1:0]     y_in,
    input  logic                        flush,
    fir_out_collector_if.master         m_if,
    output logic [$clog2(DEPTH):0]      fill_level,
    output logic                        overflow,
    output logic                        warm_done
);
    localparam int CNT_W = $clog2(N_TAPS);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Rounding constant and saturation limits, all in the widened ACC_W+1 domain
    localparam logic signed [ACC_W:0] RND     = (ACC_W+1)'(64'd1 << (SHIFT - 1));
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {WARM, RUN} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        discard_cnt;

    logic signed [ACC_W:0]   t_sum;
    logic signed [ACC_W:0]   s_shr;
    logic signed [OUT_W-1:0] s_sat;

    logic                    stage_vld;
    logic [OUT_W-1:0]        stage_dat;

    logic [OUT_W-1:0]        mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic                    full;
    logic                    pop;
    logic                    push;

    // Warm-up FSM: count off the pipeline-fill samples, then keep everything until flush
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state       <= WARM;
            discard_cnt <= '0;
            warm_done   <= 1'b0;
        end else if (flush) begin
            state       <= WARM;
            discard_cnt <= '0;
            warm_done   <= 1'b0;
        end else begin
            case (state)
                WARM: begin
                    if (sample_en) begin
                        discard_cnt <= discard_cnt + 1'b1;
                        if (discard_cnt == CNT_W'(N_TAPS - 2)) begin
                            state     <= RUN;
                            warm_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= WARM;
                end
            endcase
        end
    end

    // Round half-up, floor shift, clamp to the signed OUT_W range; the extra bit avoids wrap
    always_comb begin
        t_sum = {y_in[ACC_W-1], y_in} + RND;
        s_shr = t_sum >>> SHIFT;
        if (s_shr > SAT_MAX) begin
            s_sat = SAT_MAX[OUT_W-1:0];
        end else if (s_shr < SAT_MIN) begin
            s_sat = SAT_MIN[OUT_W-1:0];
        end else begin
            s_sat = s_shr[OUT_W-1:0];
        end
    end

    // Scale stage register: one kept sample per sample_en while running
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            stage_vld <= 1'b0;
            stage_dat <= '0;
        end else if (flush) begin
            stage_vld <= 1'b0;
        end else begin
            stage_vld <= sample_en && (state == RUN);
            if (sample_en) begin
                stage_dat <= s_sat;
            end
        end
    end

    assign full           = (fill_level == LVL_W'(DEPTH));
    assign m_if.m_valid   = (fill_level != '0);
    assign pop            = m_if.m_valid && m_if.m_ready;
    // A full FIFO still accepts a write when the head leaves on the same edge
    assign push           = stage_vld && (!full || pop);
    assign m_if.m_data    = m_if.m_valid ? mem[rd_ptr] : '0;

    // Storage array: no reset needed, contents only observed through valid entries
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= stage_dat;
        end
    end

    // FIFO pointers, occupancy and sticky overflow; flush overrides any same-edge push/pop
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            overflow   <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fill_level <= fill_level + 1'b1;
                2'b01:   fill_level <= fill_level - 1'b1;
                default: fill_level <= fill_level;
            endcase
            if (stage_vld && !push) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule
